// File: rtl/program_memory_loader.sv
// Loadable program memory: byte-stream loader with little-endian word assembly and a registered, fault-checked fetch port.
// Optional PMEM_CHECKSUM_EN builds a running XOR checksum of the words written by the current load.
module program_memory_loader #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 64,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD     = '0,
    localparam int                   CW           = $clog2(MEMORY_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic                  load_byte_valid,
    input  logic [7:0]            load_byte,
    input  logic                  load_last,
    output logic                  load_byte_ready,
    output logic                  load_done,
    output logic [CW-1:0]         words_loaded,
    input  logic                  fetch_req,
    input  logic [DATA_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] Instruction,
    output logic                  instr_valid,
    output logic                  fetch_fault,
    output logic [DATA_WIDTH-1:0] checksum
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LW    = $clog2(BYTES);
    localparam int AW    = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         lane_q;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] new_word;
    logic                  accept;
    logic                  word_done;
    logic                  load_end;
    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    // A restart in the same cycle discards the byte on the bus.
    assign accept    = load_byte_valid && load_byte_ready && !load_start;
    assign word_done = accept && (load_last || lane_q == LW'(BYTES - 1));
    assign load_end  = word_done && (load_last || words_loaded == CW'(MEMORY_DEPTH - 1));
    // Lanes above the current one are still zero, so a load_last partial word is zero-padded.
    assign new_word  = asm_q | (DATA_WIDTH'(load_byte) << {lane_q, 3'b000});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_start) state_d = LOAD;
            LOAD:    if (load_start) state_d = LOAD;
                     else if (load_end) state_d = RUN;
            RUN:     if (load_start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_byte_ready = (state_q == LOAD);
        load_done       = (state_q == RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            words_loaded <= '0;
            lane_q       <= '0;
            asm_q        <= '0;
        end else if (load_start) begin
            words_loaded <= '0;
            lane_q       <= '0;
            asm_q        <= '0;
        end else if (word_done) begin
            words_loaded <= words_loaded + CW'(1);
            lane_q       <= '0;
            asm_q        <= '0;
        end else if (accept) begin
            lane_q <= lane_q + LW'(1);
            asm_q  <= new_word;
        end
    end

    // Contents survive reset and restarts; words_loaded alone bounds what is fetchable.
    always_ff @(posedge clk) begin
        if (word_done) mem[words_loaded[AW-1:0]] <= new_word;
    end

`ifdef PMEM_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          csum_q <= '0;
        else if (load_start) csum_q <= '0;
        else if (word_done)  csum_q <= csum_q ^ new_word;
    end
    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

    logic [DATA_WIDTH-1:0] offset;
    logic [DATA_WIDTH-1:0] idx;
    logic                  fault;

    assign offset = Address - BASE_ADDRESS;
    assign idx    = offset >> LW;
    assign fault  = (state_q != RUN) || (Address[LW-1:0] != '0) ||
                    (Address < BASE_ADDRESS) || (idx >= DATA_WIDTH'(words_loaded));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Instruction <= NOP_WORD;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            instr_valid <= fetch_req;
            fetch_fault <= fetch_req && fault;
            if (fetch_req) Instruction <= fault ? NOP_WORD : mem[idx[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_program_memory_loader.sv
// Directed bench for program_memory_loader (MEMORY_DEPTH=4): load, fetch, faults, overflow, restart and reset.
module tb_program_memory_loader;
    localparam int DW = 32;
    localparam int CW = 3;

    logic          clk = 0;
    logic          reset = 0;
    logic          load_start = 0;
    logic          load_byte_valid = 0;
    logic [7:0]    load_byte = '0;
    logic          load_last = 0;
    logic          load_byte_ready;
    logic          load_done;
    logic [CW-1:0] words_loaded;
    logic          fetch_req = 0;
    logic [DW-1:0] Address = '0;
    logic [DW-1:0] Instruction;
    logic          instr_valid;
    logic          fetch_fault;
    logic [DW-1:0] checksum;

    int n_chk  = 0;
    int n_pass = 0;

    program_memory_loader #(.DATA_WIDTH(32), .MEMORY_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .load_byte_valid(load_byte_valid), .load_byte(load_byte), .load_last(load_last),
        .load_byte_ready(load_byte_ready), .load_done(load_done), .words_loaded(words_loaded),
        .fetch_req(fetch_req), .Address(Address), .Instruction(Instruction),
        .instr_valid(instr_valid), .fetch_fault(fetch_fault), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_load();
        load_start = 1; tick(); load_start = 0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        load_byte_valid = 1; load_byte = b; load_last = last;
        tick();
        load_byte_valid = 0; load_last = 0;
    endtask

    task automatic fetch(input logic [DW-1:0] a);
        fetch_req = 1; Address = a; tick(); fetch_req = 0;
    endtask

    task automatic fetch_chk(input string tag, input logic [DW-1:0] a,
                             input logic [DW-1:0] exp_w, input logic exp_f);
        fetch(a);
        chk({tag, ".valid"}, instr_valid, 1);
        chk({tag, ".fault"}, fetch_fault, exp_f);
        chk({tag, ".instr"}, Instruction, exp_w);
    endtask

    function automatic logic [DW-1:0] csum_exp(input logic [DW-1:0] x);
`ifdef PMEM_CHECKSUM_EN
        return x;
`else
        return '0;
`endif
    endfunction

    localparam logic [DW-1:0] B = 32'h0040_0000;

    initial begin
        tick(); tick();
        chk("rst.ready", load_byte_ready, 0);
        chk("rst.done", load_done, 0);
        chk("rst.words", words_loaded, 0);
        chk("rst.valid", instr_valid, 0);
        chk("rst.fault", fetch_fault, 0);
        chk("rst.instr", Instruction, 0);
        chk("rst.csum", checksum, 0);
        reset = 1; tick();

        // Two full words, little-endian.
        start_load();
        chk("load.ready", load_byte_ready, 1);
        send(8'h78, 0); send(8'h56, 0); send(8'h34, 0); send(8'h12, 0);
        chk("load.w1", words_loaded, 1);
        chk("load.done_early", load_done, 0);
        send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 1);
        chk("load.done", load_done, 1);
        chk("load.words", words_loaded, 2);
        chk("load.ready_off", load_byte_ready, 0);
        chk("load.csum", checksum, csum_exp(32'h1234_5678 ^ 32'hDEAD_BEEF));
        fetch_chk("f4", B + 4, 32'hDEAD_BEEF, 0);
        fetch_chk("f0", B, 32'h1234_5678, 0);
        tick();
        chk("idle.valid", instr_valid, 0);
        chk("idle.fault", fetch_fault, 0);
        chk("idle.hold", Instruction, 32'h1234_5678);

        fetch_chk("mis", B + 2, 32'h0, 1);
        fetch_chk("below", 32'h003F_FFFC, 32'h0, 1);
        fetch_chk("unl", B + 8, 32'h0, 1);

        // Back-to-back fetches at full throughput.
        fetch_req = 1; Address = B; tick();
        chk("b2b0.valid", instr_valid, 1); chk("b2b0.instr", Instruction, 32'h1234_5678);
        Address = B + 4; tick();
        chk("b2b1.valid", instr_valid, 1); chk("b2b1.instr", Instruction, 32'hDEAD_BEEF);
        Address = B; tick();
        chk("b2b2.valid", instr_valid, 1); chk("b2b2.instr", Instruction, 32'h1234_5678);
        fetch_req = 0; tick();
        chk("b2b.end", instr_valid, 0);

        // load_start with fetch in RUN: fetch served from the old image.
        load_start = 1; fetch_req = 1; Address = B + 4; tick();
        load_start = 0; fetch_req = 0;
        chk("sim.valid", instr_valid, 1);
        chk("sim.fault", fetch_fault, 0);
        chk("sim.instr", Instruction, 32'hDEAD_BEEF);
        chk("sim.ready", load_byte_ready, 1);
        chk("sim.words", words_loaded, 0);
        chk("sim.csum", checksum, 0);
        fetch_chk("inload", B, 32'h0, 1);

        // Partial word closed by load_last.
        send(8'hAA, 0); send(8'hBB, 1);
        chk("part.words", words_loaded, 1);
        chk("part.done", load_done, 1);
        chk("part.csum", checksum, csum_exp(32'h0000_BBAA));
        fetch_chk("part0", B, 32'h0000_BBAA, 0);
        fetch_chk("part1", B + 4, 32'h0, 1);

        // Restart with a simultaneous byte: the byte is dropped.
        start_load();
        send(8'h11, 0);
        load_start = 1; load_byte_valid = 1; load_byte = 8'h22; tick();
        load_start = 0; load_byte_valid = 0;
        chk("rs.words", words_loaded, 0);
        send(8'h33, 0); send(8'h44, 0); send(8'h55, 0); send(8'h66, 1);
        chk("rs.words1", words_loaded, 1);
        fetch_chk("rs", B, 32'h6655_4433, 0);

        // Overflow at MEMORY_DEPTH=4.
        start_load();
        for (int i = 1; i <= 16; i++) send(8'(i), 0);
        chk("ovf.done", load_done, 1);
        chk("ovf.words", words_loaded, 4);
        chk("ovf.ready", load_byte_ready, 0);
        for (int i = 17; i <= 20; i++) send(8'(i), 0);
        chk("ovf.words2", words_loaded, 4);
        chk("ovf.csum", checksum,
            csum_exp(32'h0403_0201 ^ 32'h0807_0605 ^ 32'h0C0B_0A09 ^ 32'h100F_0E0D));
        fetch_chk("ovf0", B, 32'h0403_0201, 0);
        fetch_chk("ovf3", B + 12, 32'h100F_0E0D, 0);

        // Asynchronous reset mid-load.
        start_load();
        for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i), 0);
        chk("mid.words_pre", words_loaded, 1);
        reset = 0; #2;
        chk("mid.ready", load_byte_ready, 0);
        chk("mid.done", load_done, 0);
        chk("mid.words", words_loaded, 0);
        chk("mid.csum", checksum, 0);
        tick(); reset = 1; tick();
        fetch_chk("mid", B, 32'h0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
